// File: rtl/test_ctrl_pkg.sv
// Shared types for the CPU test controller: run-state encoding and trace entry layout.
package test_ctrl_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } trace_entry_t;

endpackage

// File: rtl/trace_ring_buffer.sv
// Ring buffer of recent register writes; index 0 reads back the newest entry,
// one cycle after the index is presented.
module trace_ring_buffer
    import test_ctrl_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  trace_entry_t               wr_entry,
    input  logic [$clog2(DEPTH)-1:0]   rd_index,
    output trace_entry_t               rd_entry,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IDX_W = $clog2(DEPTH);

    trace_entry_t             mem_q [DEPTH];
    logic [IDX_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [IDX_W:0]           count_q, count_d;
    trace_entry_t             rd_q, rd_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + IDX_W'(1);
            if (count_q != (IDX_W+1)'(DEPTH))
                count_d = count_q + (IDX_W+1)'(1);
        end
        // Slots past the valid count may hold stale or uninitialised data.
        rd_d = '0;
        if ({1'b0, rd_index} < count_q)
            rd_d = mem_q[wr_ptr_q - IDX_W'(1) - rd_index];
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            rd_q     <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rd_q     <= rd_d;
        end
    end

    assign rd_entry = rd_q;
    assign count    = count_q;

endmodule

// File: rtl/cpu_test_controller.sv
// Run controller/monitor for the RV32I CPU: reset sequencing, counters, tohost/watchdog exit.
// Define TRACE_BUFFER_EN to build the register-write trace ring buffer.
module cpu_test_controller
    import test_ctrl_pkg::*;
#(
    parameter int          RESET_CYCLES   = 2,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0FFC,
    parameter int          CNT_W          = 32,
    parameter int          TRACE_DEPTH    = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic                             cpu_reset,
    input  logic                             retire_valid,
    input  logic                             reg_write_en,
    input  logic [4:0]                       rd_address,
    input  logic [31:0]                      rd_data,
    input  logic                             mem_write_en,
    input  logic [31:0]                      mem_write_address,
    input  logic [31:0]                      mem_write_data,
    input  logic [$clog2(TRACE_DEPTH)-1:0]   trace_index,
    output logic [4:0]                       trace_rd,
    output logic [31:0]                      trace_data,
    output logic [$clog2(TRACE_DEPTH):0]     trace_count,
    output logic [1:0]                       state,
    output logic                             done,
    output logic                             pass,
    output logic                             timeout,
    output logic [30:0]                      exit_code,
    output logic [CNT_W-1:0]                 cycle_count,
    output logic [CNT_W-1:0]                 instret_count
);

    localparam int HOLD_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

    ctrl_state_t       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [30:0]       exit_q, exit_d;

    logic exit_write, wdog_fire, trace_wr_en;

    assign exit_write  = mem_write_en && (mem_write_address == TOHOST_ADDR) && mem_write_data[0];
    assign wdog_fire   = (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign trace_wr_en = (state_q == RUN) && reg_write_en && (rd_address != 5'd0);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        cpu_reset_d = cpu_reset_q;
        cycle_d     = cycle_q;
        instret_d   = instret_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        exit_d      = exit_q;
        case (state_q)
            HOLD: begin
                cpu_reset_d = 1'b1;
                hold_d      = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_W'(RESET_CYCLES - 1)) begin
                    state_d     = RUN;
                    cpu_reset_d = 1'b0;
                end
            end
            RUN: begin
                // Exit write is checked first so it beats a simultaneous watchdog.
                if (exit_write) begin
                    state_d     = DONE;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b1;
                    exit_d      = mem_write_data[31:1];
                    pass_d      = (mem_write_data[31:1] == 31'd0);
                end else if (wdog_fire) begin
                    state_d     = DONE;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b1;
                    timeout_d   = 1'b1;
                    pass_d      = 1'b0;
                end else begin
                    cycle_d = cycle_q + CNT_W'(1);
                    if (retire_valid)
                        instret_d = instret_q + CNT_W'(1);
                end
            end
            DONE:    cpu_reset_d = 1'b1;
            default: state_d = HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HOLD;
            hold_q      <= '0;
            cpu_reset_q <= 1'b1;
            cycle_q     <= '0;
            instret_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            exit_q      <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cpu_reset_q <= cpu_reset_d;
            cycle_q     <= cycle_d;
            instret_q   <= instret_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            exit_q      <= exit_d;
        end
    end

    assign cpu_reset     = cpu_reset_q;
    assign state         = state_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign exit_code     = exit_q;
    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;

`ifdef TRACE_BUFFER_EN
    trace_entry_t wr_entry, rd_entry;

    assign wr_entry.rd   = rd_address;
    assign wr_entry.data = rd_data;

    trace_ring_buffer #(.DEPTH(TRACE_DEPTH)) u_trace (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (trace_wr_en),
        .wr_entry (wr_entry),
        .rd_index (trace_index),
        .rd_entry (rd_entry),
        .count    (trace_count)
    );

    assign trace_rd   = rd_entry.rd;
    assign trace_data = rd_entry.data;
`else
    logic unused_trace;
    assign unused_trace = ^{trace_wr_en, rd_data, trace_index};
    assign trace_rd     = '0;
    assign trace_data   = '0;
    assign trace_count  = '0;
`endif

endmodule

// File: tb/tb_cpu_test_controller.sv
// Randomised bench for cpu_test_controller against a queue-based reference model.
module tb_cpu_test_controller;

    localparam int          RC    = 2;
    localparam int          TO    = 64;
    localparam logic [31:0] THOST = 32'h0000_0FFC;
    localparam int          DEPTH = 16;
`ifdef TRACE_BUFFER_EN
    localparam bit TB_EN = 1'b1;
`else
    localparam bit TB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_reset;
    logic        retire_valid = 1'b0;
    logic        reg_write_en = 1'b0;
    logic [4:0]  rd_address = '0;
    logic [31:0] rd_data = '0;
    logic        mem_write_en = 1'b0;
    logic [31:0] mem_write_address = '0;
    logic [31:0] mem_write_data = '0;
    logic [3:0]  trace_index = '0;
    logic [4:0]  trace_rd;
    logic [31:0] trace_data;
    logic [4:0]  trace_count;
    logic [1:0]  state;
    logic        done, pass, timeout;
    logic [30:0] exit_code;
    logic [31:0] cycle_count, instret_count;

    cpu_test_controller #(
        .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .TOHOST_ADDR(THOST),
        .CNT_W(32), .TRACE_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .cpu_reset(cpu_reset),
        .retire_valid(retire_valid), .reg_write_en(reg_write_en),
        .rd_address(rd_address), .rd_data(rd_data),
        .mem_write_en(mem_write_en), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .trace_index(trace_index),
        .trace_rd(trace_rd), .trace_data(trace_data), .trace_count(trace_count),
        .state(state), .done(done), .pass(pass), .timeout(timeout),
        .exit_code(exit_code), .cycle_count(cycle_count), .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // reference model state
    int          m_state, m_hold, m_cpu_reset;
    longint      m_cyc, m_ins;
    bit          m_done, m_pass, m_to;
    logic [30:0] m_exit;
    logic [4:0]  m_trd;
    logic [31:0] m_tdata;
    logic [36:0] m_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [36:0] rdv;
        if (reset) begin
            m_state = 0; m_hold = 0; m_cpu_reset = 1; m_cyc = 0; m_ins = 0;
            m_done = 0; m_pass = 0; m_to = 0; m_exit = '0;
            m_trd = '0; m_tdata = '0; m_q.delete();
        end else begin
            rdv = '0;
            if (TB_EN && int'(trace_index) < m_q.size()) rdv = m_q[int'(trace_index)];
            m_trd = rdv[36:32]; m_tdata = rdv[31:0];
            case (m_state)
                0: begin
                    if (m_hold == RC - 1) begin m_state = 1; m_cpu_reset = 0; end
                    m_hold++;
                end
                1: begin
                    if (TB_EN && reg_write_en && rd_address != 0) begin
                        m_q.push_front({rd_address, rd_data});
                        if (m_q.size() > DEPTH) void'(m_q.pop_back());
                    end
                    if (mem_write_en && mem_write_address == THOST && mem_write_data[0]) begin
                        m_state = 2; m_cpu_reset = 1; m_done = 1;
                        m_exit = mem_write_data[31:1]; m_pass = (m_exit == 0);
                    end else if (m_cyc == TO - 1) begin
                        m_state = 2; m_cpu_reset = 1; m_done = 1; m_to = 1; m_pass = 0;
                    end else begin
                        m_cyc++;
                        if (retire_valid) m_ins++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all();
        check("state", 64'(state), 64'(m_state));
        check("cpu_reset", 64'(cpu_reset), 64'(m_cpu_reset));
        check("done", 64'(done), 64'(m_done));
        check("pass", 64'(pass), 64'(m_pass));
        check("timeout", 64'(timeout), 64'(m_to));
        check("exit_code", 64'(exit_code), 64'(m_exit));
        check("cycle_count", 64'(cycle_count), 64'(m_cyc[31:0]));
        check("instret_count", 64'(instret_count), 64'(m_ins[31:0]));
        check("trace_rd", 64'(trace_rd), 64'(m_trd));
        check("trace_data", 64'(trace_data), 64'(m_tdata));
        check("trace_count", 64'(trace_count), 64'(m_q.size()));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clear_in();
        retire_valid = 0; reg_write_en = 0; rd_address = '0; rd_data = '0;
        mem_write_en = 0; mem_write_address = '0; mem_write_data = '0;
    endtask

    // Random traffic that never forms an exit write; quiet on the watchdog cycle.
    task automatic rand_in();
        retire_valid = 1'($urandom);
        reg_write_en = 1'($urandom);
        rd_address   = 5'($urandom);
        rd_data      = $urandom;
        trace_index  = 4'($urandom);
        mem_write_en = 1'($urandom);
        if ($urandom_range(3) == 0) begin
            mem_write_address = THOST;
            mem_write_data    = $urandom & 32'hFFFF_FFFE;
        end else begin
            mem_write_address = $urandom;
            mem_write_data    = $urandom;
            if (mem_write_address == THOST) mem_write_data[0] = 1'b0;
        end
        if (m_state == 1 && m_cyc == TO - 1) begin
            retire_valid = 0; reg_write_en = 0;
        end
    endtask

    // Reset, then HOLD with an exit write present (must be ignored), until RUN.
    task automatic reset_to_run();
        reset = 1; rand_in(); tick();
        reset = 0;
        clear_in(); mem_write_en = 1; mem_write_address = THOST; mem_write_data = 32'h1;
        tick();
        check("hold_cpu_reset", 64'(cpu_reset), 64'd1);
        tick();
        check("run_entry_state", 64'(state), 64'd1);
        check("run_entry_cpu_reset", 64'(cpu_reset), 64'd0);
        clear_in();
    endtask

    task automatic run_random_to(input int n);
        for (int k = 0; k < 200 && m_state == 1 && m_cyc < n; k++) begin
            rand_in(); tick();
        end
        clear_in();
        check("reach_cycle", 64'(cycle_count), 64'(n));
    endtask

    task automatic exit_write(input logic [31:0] d);
        clear_in(); mem_write_en = 1; mem_write_address = THOST; mem_write_data = d;
        tick();
        clear_in();
    endtask

    initial begin
        model_edge();
        // reset held 3 cycles, then sequencing out of HOLD
        clear_in();
        repeat (3) tick();
        check("rst_state", 64'(state), 64'd0);
        check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
        reset = 0;
        tick();
        check("post1_cpu_reset", 64'(cpu_reset), 64'd1);
        check("post1_state", 64'(state), 64'd0);
        tick();
        check("post2_state", 64'(state), 64'd1);
        check("post2_cpu_reset", 64'(cpu_reset), 64'd0);

        // pass exit at RUN cycle 10
        run_random_to(10);
        exit_write(32'h1);
        check("exit1_done", 64'(done), 64'd1);
        check("exit1_pass", 64'(pass), 64'd1);
        check("exit1_code", 64'(exit_code), 64'd0);
        check("exit1_cycle", 64'(cycle_count), 64'd10);
        // DONE ignores inputs, including another exit write
        for (int k = 0; k < 4; k++) begin rand_in(); tick(); end
        exit_write(32'h9);
        check("done_hold_code", 64'(exit_code), 64'd0);

        // even tohost write ignored, then failing exit code
        reset_to_run();
        run_random_to(5);
        exit_write(32'h2);
        check("even_ignored", 64'(done), 64'd0);
        exit_write(32'h7);
        check("exit7_done", 64'(done), 64'd1);
        check("exit7_pass", 64'(pass), 64'd0);
        check("exit7_code", 64'(exit_code), 64'd3);

        // mid-RUN reset, then watchdog
        reset_to_run();
        run_random_to(7);
        reset_to_run();
        for (int k = 0; k < 200 && m_state == 1; k++) begin rand_in(); tick(); end
        clear_in();
        check("wdog_done", 64'(done), 64'd1);
        check("wdog_timeout", 64'(timeout), 64'd1);
        check("wdog_pass", 64'(pass), 64'd0);
        check("wdog_cycle", 64'(cycle_count), 64'(TO - 1));

        // trace buffer fill
        reset_to_run();
        trace_index = 4'd3;
        tick();
        check("trace_empty_rd", 64'(trace_rd), 64'd0);
        for (int i = 1; i <= 20; i++) begin
            clear_in(); reg_write_en = 1; rd_address = 5'(i); rd_data = i;
            if (i == 4) trace_index = 4'd5;
            tick();
            if (i == 4) begin
                check("trace_oob_rd", 64'(trace_rd), 64'd0);
                check("trace_oob_data", 64'(trace_data), 64'd0);
            end
            if (i == 10) begin
                clear_in(); reg_write_en = 1; rd_address = 5'd0; rd_data = 32'hDEAD;
                tick();
            end
        end
        clear_in();
`ifdef TRACE_BUFFER_EN
        check("trace_count16", 64'(trace_count), 64'd16);
        for (int k = 0; k < 16; k++) begin
            trace_index = 4'(k);
            tick();
            check("trace_rd_k", 64'(trace_rd), 64'(20 - k));
            check("trace_data_k", 64'(trace_data), 64'(20 - k));
        end
`else
        trace_index = 4'd0;
        tick();
        check("trace_off_count", 64'(trace_count), 64'd0);
        check("trace_off_rd", 64'(trace_rd), 64'd0);
`endif

        // exit write and watchdog together: exit wins
        reset_to_run();
        run_random_to(TO - 1);
        exit_write(32'h1);
        check("race_done", 64'(done), 64'd1);
        check("race_pass", 64'(pass), 64'd1);
        check("race_timeout", 64'(timeout), 64'd0);
        reset = 1;
        tick();
        check("done_rst_state", 64'(state), 64'd0);
        check("done_rst_done", 64'(done), 64'd0);
        check("done_rst_cycle", 64'(cycle_count), 64'd0);
        check("done_rst_cpu_reset", 64'(cpu_reset), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
